// File: rtl/spi_xfer_arbiter.sv
// Round-robin sequencer sharing one byte-serial SPI shifter among NREQ clients.
// Optional watchdog on the shifter completion: define SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic               counter_clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [NREQ-1:0]    cs_n,
    output logic               spi_start,
    output logic [DW-1:0]      spi_tx_byte,
    input  logic               spi_busy,
    input  logic               spi_done,
    input  logic [DW-1:0]      spi_rx_byte
);

    localparam int IW = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_WAIT_DONE,
        S_CS_HOLD,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [NREQ-1:0] cs_n_q, cs_n_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   tx_q, tx_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic [7:0]      gap_q, gap_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan_idx;
    logic            scan_hit;
    logic [DW-1:0]   win_data;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            to_flag_q, to_flag_d;
    logic            err_q, err_d;
`endif

    // Scan starts one past the last winner, giving strict rotation.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        scan_hit  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IW'((int'(ptr_q) + k) % NREQ);
            scan_hit = 1'b0;
            for (int m = 0; m < NREQ; m++) begin
                if (IW'(m) == scan_idx && req[m]) begin
                    scan_hit = 1'b1;
                end
            end
            if (!win_found && scan_hit) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_idx) begin
                win_data = wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cs_n_d    = cs_n_q;
        ack_d     = '0;
        tx_d      = tx_q;
        rdata_d   = rdata_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        gap_d     = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_CS_SETUP;
                    ptr_d   = win_idx;
                    grant_d = win_idx;
                    tx_d    = win_data;
                    busy_d  = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        cs_n_d[i] = (IW'(i) != win_idx);
                    end
                end
            end
            S_CS_SETUP: begin
                if (!spi_busy) begin
                    state_d = S_WAIT_DONE;
                    start_d = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_d  = '0;
                    to_flag_d = 1'b0;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (spi_done) begin
                    state_d = S_CS_HOLD;
                    rdata_d = spi_rx_byte;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (int'(to_cnt_q) >= TIMEOUT - 1) begin
                    state_d   = S_CS_HOLD;
                    rdata_d   = '0;
                    to_flag_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_CS_HOLD: begin
                cs_n_d = '1;
                gap_d  = '0;
                for (int i = 0; i < NREQ; i++) begin
                    ack_d[i] = (IW'(i) == grant_q);
                end
`ifdef SPI_ARB_TIMEOUT_EN
                err_d = to_flag_q;
`endif
                if (GAP_CYCLES == 0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (int'(gap_q) >= GAP_CYCLES - 1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge counter_clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= IW'(NREQ - 1);
            grant_q   <= '0;
            cs_n_q    <= '1;
            ack_q     <= '0;
            tx_q      <= '0;
            rdata_q   <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cs_n_q    <= cs_n_d;
            ack_q     <= ack_d;
            tx_q      <= tx_d;
            rdata_q   <= rdata_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            gap_q     <= gap_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge counter_clk) begin
        if (!reset) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign cs_n        = cs_n_q;
    assign spi_start   = start_q;
    assign spi_tx_byte = tx_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter (NREQ=4, DW=8, GAP_CYCLES=2).
module tb_spi_xfer_arbiter;

    logic        counter_clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic [2:0]  grant_id;
    logic [3:0]  cs_n;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rx_byte;

    int errors = 0;
    int checks = 0;

    spi_xfer_arbiter #(
        .NREQ(4), .DW(8), .GAP_CYCLES(2), .TIMEOUT(255)
    ) dut (
        .counter_clk(counter_clk),
        .reset(reset),
        .req(req),
        .wdata(wdata),
        .ack(ack),
        .rdata(rdata),
        .err(err),
        .busy(busy),
        .grant_id(grant_id),
        .cs_n(cs_n),
        .spi_start(spi_start),
        .spi_tx_byte(spi_tx_byte),
        .spi_busy(spi_busy),
        .spi_done(spi_done),
        .spi_rx_byte(spi_rx_byte)
    );

    always #5 counter_clk = ~counter_clk;

    task automatic tick();
        @(posedge counter_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (cs_n !== 4'hF) begin
            errors++; $display("FAIL reset_cs: got %b want 1111", cs_n);
        end
        checks++;
        if ({busy, spi_start, err, ack} !== 7'd0) begin
            errors++; $display("FAIL reset_ctl: busy=%b start=%b err=%b ack=%b want 0", busy, spi_start, err, ack);
        end
        checks++;
        if ({grant_id, spi_tx_byte, rdata} !== 19'd0) begin
            errors++; $display("FAIL reset_data: gid=%0d tx=%h rd=%h want 0", grant_id, spi_tx_byte, rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0100;
        wdata[23:16] = 8'hA5;
        tick();
        checks++;
        if (cs_n !== 4'b1011 || busy !== 1'b1 || grant_id !== 3'd2) begin
            errors++; $display("FAIL single_grant: cs=%b busy=%b gid=%0d want 1011 1 2", cs_n, busy, grant_id);
        end
        checks++;
        if (spi_tx_byte !== 8'hA5 || spi_start !== 1'b0) begin
            errors++; $display("FAIL single_tx: tx=%h start=%b want a5 0", spi_tx_byte, spi_start);
        end
        tick();
        checks++;
        if (spi_start !== 1'b1) begin
            errors++; $display("FAIL single_start: got %b want 1", spi_start);
        end
        tick();
        checks++;
        if (spi_start !== 1'b0 || cs_n !== 4'b1011) begin
            errors++; $display("FAIL single_start_pulse: start=%b cs=%b want 0 1011", spi_start, cs_n);
        end
        spi_done = 1'b1;
        spi_rx_byte = 8'h3C;
        tick();
        spi_done = 1'b0;
        checks++;
        if (ack !== 4'b0000 || cs_n !== 4'b1011) begin
            errors++; $display("FAIL single_hold: ack=%b cs=%b want 0000 1011", ack, cs_n);
        end
        tick();
        checks++;
        if (ack !== 4'b0100 || rdata !== 8'h3C || err !== 1'b0) begin
            errors++; $display("FAIL single_ack: ack=%b rd=%h err=%b want 0100 3c 0", ack, rdata, err);
        end
        checks++;
        if (cs_n !== 4'hF) begin
            errors++; $display("FAIL single_cs_release: got %b want 1111", cs_n);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0000 || cs_n !== 4'hF || busy !== 1'b1) begin
            errors++; $display("FAIL single_gap1: ack=%b cs=%b busy=%b want 0000 1111 1", ack, cs_n, busy);
        end
        tick();
        checks++;
        if (cs_n !== 4'hF || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: cs=%b busy=%b want 1111 0", cs_n, busy);
        end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_cs;
        logic [3:0] exp_ack;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wdata = 32'h13121110;
        req = 4'hF;
        for (int f = 0; f < 5; f++) begin
            exp_ack = 4'b0001 << order[f];
            exp_cs = ~exp_ack;
            tick();
            checks++;
            if (grant_id !== 3'(order[f]) || cs_n !== exp_cs) begin
                errors++; $display("FAIL rr_grant%0d: gid=%0d cs=%b want %0d %b", f, grant_id, cs_n, order[f], exp_cs);
            end
            checks++;
            if (spi_tx_byte !== 8'(8'h10 + order[f])) begin
                errors++; $display("FAIL rr_tx%0d: got %h want %h", f, spi_tx_byte, 8'(8'h10 + order[f]));
            end
            tick();
            spi_done = 1'b1;
            spi_rx_byte = 8'(8'hC0 + f);
            tick();
            spi_done = 1'b0;
            tick();
            checks++;
            if (ack !== exp_ack || rdata !== 8'(8'hC0 + f)) begin
                errors++; $display("FAIL rr_ack%0d: ack=%b rd=%h want %b %h", f, ack, rdata, exp_ack, 8'(8'hC0 + f));
            end
            if (f == 4) req = 4'h0;
            tick();
            checks++;
            if (cs_n !== 4'hF) begin
                errors++; $display("FAIL rr_gap_a%0d: got %b want 1111", f, cs_n);
            end
            tick();
            checks++;
            if (cs_n !== 4'hF || busy !== 1'b0) begin
                errors++; $display("FAIL rr_gap_b%0d: cs=%b busy=%b want 1111 0", f, cs_n, busy);
            end
        end
    endtask

    task automatic test_busy_holdoff();
        spi_busy = 1'b1;
        req = 4'b0010;
        wdata[15:8] = 8'h6E;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (spi_start !== 1'b0 || cs_n !== 4'b1101) begin
                errors++; $display("FAIL busy_hold%0d: start=%b cs=%b want 0 1101", c, spi_start, cs_n);
            end
        end
        spi_busy = 1'b0;
        tick();
        checks++;
        if (spi_start !== 1'b1 || spi_tx_byte !== 8'h6E) begin
            errors++; $display("FAIL busy_start: start=%b tx=%h want 1 6e", spi_start, spi_tx_byte);
        end
        spi_done = 1'b1;
        spi_rx_byte = 8'h91;
        tick();
        spi_done = 1'b0;
        tick();
        checks++;
        if (ack !== 4'b0010 || rdata !== 8'h91) begin
            errors++; $display("FAIL busy_ack: ack=%b rd=%h want 0010 91", ack, rdata);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b1000;
        wdata[31:24] = 8'h44;
        tick();
        checks++;
        if (grant_id !== 3'd3 || cs_n !== 4'b0111) begin
            errors++; $display("FAIL rst_mid_grant: gid=%0d cs=%b want 3 0111", grant_id, cs_n);
        end
        tick();
        tick();
        reset = 1'b0;
        req = 4'b1001;
        wdata[7:0] = 8'h0A;
        tick();
        checks++;
        if (cs_n !== 4'hF || ack !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop: cs=%b ack=%b busy=%b want 1111 0000 0", cs_n, ack, busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (grant_id !== 3'd0 || cs_n !== 4'b1110 || ack !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_regrant: gid=%0d cs=%b ack=%b want 0 1110 0000", grant_id, cs_n, ack);
        end
        tick();
        spi_done = 1'b1;
        spi_rx_byte = 8'hB2;
        tick();
        spi_done = 1'b0;
        tick();
        checks++;
        if (ack !== 4'b0001 || rdata !== 8'hB2) begin
            errors++; $display("FAIL rst_mid_ack: ack=%b rd=%h want 0001 b2", ack, rdata);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_withdraw_stray();
        spi_done = 1'b1;
        spi_rx_byte = 8'hFF;
        tick();
        spi_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || cs_n !== 4'hF || ack !== 4'b0000) begin
            errors++; $display("FAIL stray_idle: busy=%b cs=%b ack=%b want 0 1111 0000", busy, cs_n, ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0000 || spi_start !== 1'b0) begin
            errors++; $display("FAIL stray_noack: ack=%b start=%b want 0000 0", ack, spi_start);
        end
        req = 4'b1000;
        wdata[31:24] = 8'h77;
        tick();
        checks++;
        if (grant_id !== 3'd3 || cs_n !== 4'b0111 || spi_tx_byte !== 8'h77) begin
            errors++; $display("FAIL wd_grant: gid=%0d cs=%b tx=%h want 3 0111 77", grant_id, cs_n, spi_tx_byte);
        end
        req = 4'b1010;
        tick();
        req = 4'b1000;
        spi_done = 1'b1;
        spi_rx_byte = 8'h5A;
        tick();
        spi_done = 1'b0;
        tick();
        checks++;
        if (ack !== 4'b1000 || rdata !== 8'h5A) begin
            errors++; $display("FAIL wd_ack: ack=%b rd=%h want 1000 5a", ack, rdata);
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || cs_n !== 4'hF) begin
            errors++; $display("FAIL wd_withdrawn: busy=%b cs=%b want 0 1111", busy, cs_n);
        end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        req = 4'b0001;
        wdata[7:0] = 8'h12;
        tick();
        tick();
        for (int c = 0; c < 255; c++) begin
            tick();
            if (ack !== 4'b0000) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL to_early: %0d early ack cycles want 0", early);
        end
        tick();
        checks++;
        if (ack !== 4'b0001 || err !== 1'b1 || rdata !== 8'h00) begin
            errors++; $display("FAIL to_ack: ack=%b err=%b rd=%h want 0001 1 00", ack, err, rdata);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b0;
        req = '0;
        wdata = '0;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        spi_rx_byte = '0;
        test_reset();
        test_single();
        test_rotation();
        test_busy_holdoff();
        test_reset_mid();
        test_withdraw_stray();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
